// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// UART receiver. Recovers serial frames from the asynchronous rx line using the
// oversample tick from the baud generator. It validates the start bit, shifts in
// LSB-first data, and optionally checks a parity bit. It samples the stop bit
// and hands each word to the downstream consumer over a valid/ready interface.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset (overrides everything)
//   b_clk       oversample tick, one clk wide, OVS ticks per bit period
//   rx          asynchronous serial input, idle high
//   rx_data     received word (stable while rx_valid is held)
//   rx_valid    rx_data and its status flags are valid
//   rx_ready    consumer accepts the word this cycle
//   frame_err   stop bit was sampled low for the word on rx_data
//   parity_err  parity mismatch for the word on rx_data
//   overrun     sticky; a finished frame was dropped because rx_valid was held
//   busy        receiver is somewhere in a frame (not IDLE)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned DATA_W     = 8,     // data bits per frame, 5..9
  parameter int unsigned OVS        = 16,    // ticks per bit, even, >= 4
  parameter bit          PARITY_EN  = 1'b0,  // parity bit follows the data
  parameter bit          PARITY_ODD = 1'b0   // 1: odd parity, 0: even parity
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b_clk,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(OVS);
  localparam int unsigned IDX_W = $clog2(DATA_W + 1);

  // Start bit is checked at its midpoint. Every later state then runs one full
  // bit period, so each of its samples also falls mid-bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]        sync_q;            // [0] metastable stage, [1] = rxs
  logic              rxs;

  state_e            state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic              perr_q,   perr_d;  // parity result of the frame in flight
  logic              armed_q,  armed_d;

  logic [DATA_W-1:0] data_q,   data_d;
  logic              valid_q,  valid_d;
  logic              ferr_q,   ferr_d;
  logic              par_q,    par_d;
  logic              ovr_q,    ovr_d;

  logic              complete;          // stop-bit sample tick this cycle
  logic              xfer;              // handshake completes this cycle

  assign rxs  = sync_q[1];
  assign xfer = valid_q && rx_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first. Otherwise a path that does not
    // assign it would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    armed_d  = armed_q | rxs;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = ferr_q;
    par_d    = par_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // armed blocks a line that is still low (break) from starting a frame.
        if (armed_q && !rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end

      ST_START: begin
        if (b_clk) begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            if (!rxs) begin
              state_d = ST_DATA;
              idx_d   = '0;
              perr_d  = 1'b0;
            end else begin
              // Glitch shorter than half a bit: false start, no output change.
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (b_clk) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[DATA_W-1:1]};   // LSB arrives first
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = PARITY_EN ? ST_PARITY : ST_STOP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (b_clk) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            perr_d  = ((^shift_q) ^ rxs) != PARITY_ODD;
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (b_clk) begin
          if (cnt_q == CNT_LAST) begin
            // Leaving at mid-stop leaves half a bit to catch the next start.
            cnt_d    = '0;
            state_d  = ST_IDLE;
            complete = 1'b1;
            // A low stop bit may be the start of a break. Disarm so the line
            // must go high before another frame can start.
            if (!rxs) begin
              armed_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Output register / handshake. A completion that coincides with a transfer
    // counts as a delivery, so it clears overrun instead of setting it.
    if (complete) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        ferr_d  = !rxs;
        par_d   = perr_q;
        valid_d = 1'b1;
        if (xfer) begin
          ovr_d = 1'b0;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, and the result does not depend on the order of
    // evaluation.
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      par_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      par_q   <= par_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = par_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

  // A word offered to the consumer must not change or vanish before it is taken.
  a_hold_until_xfer : assert property (
    @(posedge clk) disable iff (rst)
      (rx_valid && !rx_ready) |=> (rx_valid && $stable(rx_data))
  );

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that recovers serial frames from the `rx` line using the oversampled baud tick produced by the baud generator (`b_clk`, one `clk`-wide pulse per oversample period).
- Handles start bit validation, LSB-first data, optional parity and stop bit check.
- Presents each received word on a valid/ready interface to the downstream consumer (RX FIFO or register bank), with per-frame framing/parity status and a sticky overrun flag.

Parameters:
- DATA_W, 8: data bits per frame (5..9).
- OVS, 16: `b_clk` ticks per bit period; even, >= 4.
- PARITY_EN, 0: 1 = parity bit present after data.
- PARITY_ODD, 0: 1 = odd parity, 0 = even (used only if PARITY_EN=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- b_clk  in  1  oversample tick from baud generator, one clk cycle wide
- rx  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_W  received word
- rx_valid  out  1  rx_data/status valid
- rx_ready  in  1  consumer accepts word
- frame_err  out  1  stop bit sampled low for the word on rx_data
- parity_err  out  1  parity mismatch for the word on rx_data
- overrun  out  1  sticky: a frame was dropped because rx_valid was held
- busy  out  1  receiver not in IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
  - All state is updated on posedge `clk` only.
  - `rst` overrides everything, including mid-frame.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
  - State=IDLE, counters=0, synchroniser flops=1, armed=0.
- Input sync:
  - 2-flop synchroniser on `rx`; all logic uses the synced value `rxs`.
  - Latency is 2 clk.
- Tick counter `cnt`:
  - Width clog2(OVS); advances only in cycles where b_clk=1.
  - Cleared on every state change.
  - Bit counter `idx` has width clog2(DATA_W+1).
- `armed` flag:
  - Set in any cycle with rxs=1.
  - Cleared on entering START.
  - Prevents a held-low line (break) from retriggering frames.
- State transitions:
  - IDLE:
    - If armed && rxs==0 -> START, cnt=0.
    - busy=0 only in IDLE.
  - START:
    - On the tick where cnt==OVS/2-1 (start-bit midpoint): if rxs==0 -> DATA, idx=0.
    - Otherwise it is a false start -> IDLE, with no output change.
  - DATA:
    - On the tick where cnt==OVS-1: shift rxs into the shift register MSB end (shift right, so LSB-first), then idx++.
    - When idx reaches DATA_W -> PARITY if PARITY_EN, else STOP.
  - PARITY:
    - On the tick where cnt==OVS-1: compute perr = (^data ^ rxs) != PARITY_ODD -> STOP.
  - STOP:
    - On the tick where cnt==OVS-1 (stop-bit midpoint): complete the frame -> IDLE.
    - Returning at mid-stop leaves half a bit of margin to detect the next start edge.
- Frame completion (cycle after the stop-sample tick):
  - Delivery case: if !rx_valid, or (rx_valid && rx_ready) in the same cycle, then:
    - rx_data <= shift register.
    - frame_err <= (rxs==0).
    - parity_err <= perr (0 when PARITY_EN=0).
    - rx_valid <= 1.
  - Overrun case: otherwise the frame is dropped. rx_data and its status are unchanged, and overrun <= 1.
- Handshake:
  - A transfer occurs on rx_valid && rx_ready.
  - rx_valid and rx_data are stable until the transfer.
  - On transfer with no simultaneous completion: rx_valid <= 0.
  - On transfer overrun <= 0; simultaneous completion is a delivery, so no overrun.
- Framing errors:
  - Words with frame_err=1 are still delivered.
  - After a break (rx stuck low), no new START until rxs has been 1 for at least one cycle.
- Latency: rx_valid rises 1 clk after the stop-midpoint tick, i.e. about (1 + DATA_W + PARITY_EN + 0.5) bit periods after the start edge, plus 2 clk of sync.

Test Plan:
- Common setup: OVS=16, b_clk pulsed every 4 clk, so 1 bit = 64 clk. Default rx_ready=1.
- 1: Send 0x55, stop=1 -> one frame with rx_data=0x55, rx_valid high exactly 1 cycle, frame_err=0, parity_err=0, overrun=0; busy falls at stop midpoint.
- 2: rx low for 12 clk (3 ticks) then high -> START aborts at cnt=7, busy returns to 0, rx_valid never asserts.
- 3: Send 0xA3 with stop bit 0, then hold rx low for 5 bit times -> rx_data=0xA3, frame_err=1, exactly one rx_valid; no second frame until rx returns high; then 0x0F is received cleanly.
- 4: PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity bit 0 -> parity_err=1. Send 0x07 with parity bit 1 -> parity_err=0.
- 5: rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1 after the second stop. Pulse rx_ready for 1 cycle -> rx_valid=0, overrun=0. Then send 0x33 -> received.
- 6: Assert rst for 1 clk during data bit 3 of a frame -> next cycle all outputs at reset values, busy=0; a subsequent 0x3C frame is received correctly.
